// File: rtl/mhbf_cfg_pkg.sv
// Shared types and frame-geometry helpers for the MHBF configuration distributor.
package mhbf_cfg_pkg;

    localparam int N_STAGE_DEF  = 5;
    localparam int COEF_W_DEF   = 24;
    localparam int TAPS_MAX_DEF = 32;
    localparam int TMO_CYC_DEF  = 4096;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        LOAD,
        PUSH,
        WAIT,
        DONE,
        RUN,
        ERR
    } state_t;

    // A stage block holds the coefficients plus three control words.
    function automatic int blkLen(input int tapsMax);
        return tapsMax + 3;
    endfunction

    function automatic int frameTotal(input int nStage, input int tapsMax);
        return 1 + nStage * blkLen(tapsMax);
    endfunction

endpackage

// File: rtl/mhbf_cfg_buf.sv
// Frame buffer: one write port, one combinational read port per stage, plus the header mask.
module mhbf_cfg_buf #(
    parameter int N_STAGE = 5,
    parameter int COEF_W  = 24,
    parameter int DEPTH   = 176,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              wrEn,
    input  logic [AW-1:0]                     wrAddr,
    input  logic [COEF_W-1:0]                 wrData,
    input  logic [N_STAGE-1:0][AW-1:0]        rdAddr,
    output logic [N_STAGE-1:0][COEF_W-1:0]    rdData,
    output logic [N_STAGE-1:0]                hdrMask
);

    logic [COEF_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_STAGE; gi++) begin : g_rd
            assign rdData[gi] = mem[rdAddr[gi]];
        end
    endgenerate

    assign hdrMask = mem[0][N_STAGE-1:0];

endmodule

// File: rtl/mhbf_cfg_dist.sv
// Buffers one MHBF configuration frame, broadcasts the stage blocks and tracks stage completion.
// Optional trailing checksum word enabled by defining CFG_CHECKSUM_EN.
module mhbf_cfg_dist
    import mhbf_cfg_pkg::*;
#(
    parameter int N_STAGE  = N_STAGE_DEF,
    parameter int COEF_W   = COEF_W_DEF,
    parameter int TAPS_MAX = TAPS_MAX_DEF,
    parameter int TMO_CYC  = TMO_CYC_DEF
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        cfg_req_i,
    input  logic                        cfg_vld_i,
    input  logic [COEF_W-1:0]           cfg_data_i,
    output logic                        cfg_ack_o,
    output logic                        cfg_done_o,
    output logic                        cfg_err_o,
    output logic [N_STAGE-1:0]          stg_load_o,
    output logic                        stg_vld_o,
    output logic [COEF_W*N_STAGE-1:0]   stg_data_o,
    input  logic [N_STAGE-1:0]          stg_done_i,
    output logic [N_STAGE-1:0]          stg_en_o,
    output logic                        busy_o
);

    localparam int BLK_LEN = blkLen(TAPS_MAX);
    localparam int TOTAL   = frameTotal(N_STAGE, TAPS_MAX);
`ifdef CFG_CHECKSUM_EN
    localparam int TOTAL_RX = TOTAL + 1;
`else
    localparam int TOTAL_RX = TOTAL;
`endif
    localparam int AW    = $clog2(TOTAL);
    localparam int WC_W  = $clog2(TOTAL_RX);
    localparam int PC_W  = $clog2(BLK_LEN);
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(TOTAL_RX - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(BLK_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

    state_t                           stateReg, stateNext;
    logic [WC_W-1:0]                  wcntReg, wcntNext;
    logic [PC_W-1:0]                  pcntReg, pcntNext;
    logic [TMO_W-1:0]                 tmoReg, tmoNext;
    logic [N_STAGE-1:0]               maskReg, maskNext;
    logic                             ackReg, ackNext;
    logic                             doneReg, doneNext;
    logic                             errReg, errNext;
    logic [N_STAGE-1:0]               loadReg, loadNext;
    logic                             vldReg, vldNext;
    logic [N_STAGE-1:0][COEF_W-1:0]   dataReg, dataNext;
    logic [N_STAGE-1:0]               enReg, enNext;
`ifdef CFG_CHECKSUM_EN
    logic [COEF_W-1:0]                sumReg, sumNext;
`endif

    logic                             bufWrEn;
    logic [PC_W-1:0]                  rdIdx;
    logic [N_STAGE-1:0][AW-1:0]       rdAddr;
    logic [N_STAGE-1:0][COEF_W-1:0]   rdData;
    logic [N_STAGE-1:0]               hdrMask;

`ifdef CFG_CHECKSUM_EN
    // The checksum word is compared on the fly and never stored.
    assign bufWrEn = (stateReg == RECV) && cfg_vld_i && (wcntReg != WC_LAST);
`else
    assign bufWrEn = (stateReg == RECV) && cfg_vld_i;
`endif

    // Address the word to be presented after the next edge; LOAD pre-fetches word 0.
    assign rdIdx = ((stateReg == PUSH) && (pcntReg != PC_LAST)) ? pcntReg + PC_W'(1) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < N_STAGE; gi++) begin : g_addr
            assign rdAddr[gi] = AW'(1 + gi * BLK_LEN) + AW'(rdIdx);
        end
    endgenerate

    mhbf_cfg_buf #(
        .N_STAGE (N_STAGE),
        .COEF_W  (COEF_W),
        .DEPTH   (TOTAL),
        .AW      (AW)
    ) u_buf (
        .CLK     (CLK),
        .nRST    (nRST),
        .wrEn    (bufWrEn),
        .wrAddr  (wcntReg[AW-1:0]),
        .wrData  (cfg_data_i),
        .rdAddr  (rdAddr),
        .rdData  (rdData),
        .hdrMask (hdrMask)
    );

    always_comb begin
        stateNext = stateReg;
        wcntNext  = wcntReg;
        pcntNext  = pcntReg;
        tmoNext   = tmoReg;
        maskNext  = maskReg;
        ackNext   = ackReg;
        doneNext  = 1'b0;
        errNext   = errReg;
        loadNext  = '0;
        vldNext   = vldReg;
        dataNext  = dataReg;
        enNext    = enReg;
`ifdef CFG_CHECKSUM_EN
        sumNext   = sumReg;
`endif
        case (stateReg)
            IDLE, RUN, ERR: begin
                if (cfg_req_i) begin
                    stateNext = RECV;
                    ackNext   = 1'b1;
                    wcntNext  = '0;
                    enNext    = '0;
                    errNext   = 1'b0;
`ifdef CFG_CHECKSUM_EN
                    sumNext   = '0;
`endif
                end
            end
            RECV: begin
                if (cfg_vld_i) begin
                    if (wcntReg == WC_LAST) begin
                        ackNext = 1'b0;
`ifdef CFG_CHECKSUM_EN
                        if (cfg_data_i == sumReg) begin
                            stateNext = LOAD;
                        end else begin
                            stateNext = ERR;
                            errNext   = 1'b1;
                        end
`else
                        stateNext = LOAD;
`endif
                    end else begin
                        wcntNext = wcntReg + WC_W'(1);
`ifdef CFG_CHECKSUM_EN
                        sumNext  = sumReg + cfg_data_i;
`endif
                    end
                end
            end
            LOAD: begin
                maskNext = hdrMask;
                if (hdrMask == '0) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end else begin
                    stateNext = PUSH;
                    loadNext  = hdrMask;
                    vldNext   = 1'b1;
                    dataNext  = rdData;
                    pcntNext  = '0;
                end
            end
            PUSH: begin
                if (pcntReg == PC_LAST) begin
                    stateNext = WAIT;
                    vldNext   = 1'b0;
                    tmoNext   = '0;
                end else begin
                    pcntNext = pcntReg + PC_W'(1);
                    dataNext = rdData;
                end
            end
            WAIT: begin
                if ((stg_done_i & maskReg) == maskReg) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end else begin
                    tmoNext = tmoReg + TMO_W'(1);
                    if (TMO_CYC != 0 && tmoReg == TMO_LAST) begin
                        stateNext = ERR;
                        errNext   = 1'b1;
                        enNext    = '0;
                    end
                end
            end
            DONE: begin
                stateNext = RUN;
                enNext    = maskReg;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stateReg <= IDLE;
            wcntReg  <= '0;
            pcntReg  <= '0;
            tmoReg   <= '0;
            maskReg  <= '0;
            ackReg   <= 1'b0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
            loadReg  <= '0;
            vldReg   <= 1'b0;
            dataReg  <= '0;
            enReg    <= '0;
`ifdef CFG_CHECKSUM_EN
            sumReg   <= '0;
`endif
        end else begin
            stateReg <= stateNext;
            wcntReg  <= wcntNext;
            pcntReg  <= pcntNext;
            tmoReg   <= tmoNext;
            maskReg  <= maskNext;
            ackReg   <= ackNext;
            doneReg  <= doneNext;
            errReg   <= errNext;
            loadReg  <= loadNext;
            vldReg   <= vldNext;
            dataReg  <= dataNext;
            enReg    <= enNext;
`ifdef CFG_CHECKSUM_EN
            sumReg   <= sumNext;
`endif
        end
    end

    assign cfg_ack_o  = ackReg;
    assign cfg_done_o = doneReg;
    assign cfg_err_o  = errReg;
    assign stg_load_o = loadReg;
    assign stg_vld_o  = vldReg;
    assign stg_data_o = dataReg;
    assign stg_en_o   = enReg;
    assign busy_o     = !(stateReg inside {IDLE, RUN, ERR});

endmodule

// File: tb/tb_mhbf_cfg_dist.sv
// Self-checking bench for mhbf_cfg_dist: directed frames with randomized content vs. a frame-level model.
module tb_mhbf_cfg_dist;

    localparam int N_STAGE  = 5;
    localparam int COEF_W   = 24;
    localparam int TAPS_MAX = 32;
    localparam int TMO_CYC  = 100;
    localparam int BLK      = TAPS_MAX + 3;
    localparam int TOTAL    = 1 + N_STAGE * BLK;
`ifdef CFG_CHECKSUM_EN
    localparam int TOTAL_TX = TOTAL + 1;
`else
    localparam int TOTAL_TX = TOTAL;
`endif

    logic                       CLK;
    logic                       nRST;
    logic                       cfg_req_i;
    logic                       cfg_vld_i;
    logic [COEF_W-1:0]          cfg_data_i;
    logic                       cfg_ack_o;
    logic                       cfg_done_o;
    logic                       cfg_err_o;
    logic [N_STAGE-1:0]         stg_load_o;
    logic                       stg_vld_o;
    logic [COEF_W*N_STAGE-1:0]  stg_data_o;
    logic [N_STAGE-1:0]         stg_done_i;
    logic [N_STAGE-1:0]         stg_en_o;
    logic                       busy_o;

    mhbf_cfg_dist #(
        .N_STAGE  (N_STAGE),
        .COEF_W   (COEF_W),
        .TAPS_MAX (TAPS_MAX),
        .TMO_CYC  (TMO_CYC)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .cfg_req_i  (cfg_req_i),
        .cfg_vld_i  (cfg_vld_i),
        .cfg_data_i (cfg_data_i),
        .cfg_ack_o  (cfg_ack_o),
        .cfg_done_o (cfg_done_o),
        .cfg_err_o  (cfg_err_o),
        .stg_load_o (stg_load_o),
        .stg_vld_o  (stg_vld_o),
        .stg_data_o (stg_data_o),
        .stg_done_i (stg_done_i),
        .stg_en_o   (stg_en_o),
        .busy_o     (busy_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [COEF_W-1:0] frame [TOTAL_TX];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ack"},  128'(cfg_ack_o),  128'(0));
        check({tag, "_done"}, 128'(cfg_done_o), 128'(0));
        check({tag, "_err"},  128'(cfg_err_o),  128'(0));
        check({tag, "_load"}, 128'(stg_load_o), 128'(0));
        check({tag, "_vld"},  128'(stg_vld_o),  128'(0));
        check({tag, "_data"}, 128'(stg_data_o), 128'(0));
        check({tag, "_en"},   128'(stg_en_o),   128'(0));
        check({tag, "_busy"}, 128'(busy_o),     128'(0));
    endtask

    // Reference frame: header carries the mask in its low bits, payload either i or random.
    task automatic buildFrame(input logic [N_STAGE-1:0] mask, input bit incr, input bit corrupt);
        logic [COEF_W-1:0] sum;
        if (incr) frame[0] = COEF_W'(mask);
        else      frame[0] = {COEF_W'($urandom) >> N_STAGE, mask};
        for (int i = 1; i < TOTAL; i++) begin
            frame[i] = incr ? COEF_W'(i) : COEF_W'($urandom);
        end
        sum = '0;
        for (int i = 0; i < TOTAL; i++) sum = sum + frame[i];
`ifdef CFG_CHECKSUM_EN
        frame[TOTAL] = sum + COEF_W'(corrupt);
`else
        if (corrupt) $display("note: checksum corruption requested without checksum build, sum=%0h", sum);
`endif
    endtask

    task automatic sendFrame(input bit gapped);
        int idx;
        int ackCnt;
        cfg_req_i = 1'b1;
        tick();
        cfg_req_i = 1'b0;
        check("req_ack", 128'(cfg_ack_o), 128'(1));
        check("req_busy", 128'(busy_o), 128'(1));
        check("req_err_clr", 128'(cfg_err_o), 128'(0));
        idx = 0;
        ackCnt = 0;
        for (int c = 0; c < 2 * TOTAL_TX + 4 && idx < TOTAL_TX; c++) begin
            if (cfg_ack_o) ackCnt++;
            if (!gapped || (c % 2) == 0) begin
                cfg_vld_i  = 1'b1;
                cfg_data_i = frame[idx];
                idx++;
            end else begin
                cfg_vld_i  = 1'b0;
                cfg_data_i = COEF_W'($urandom);
            end
            tick();
        end
        cfg_vld_i = 1'b0;
        check("recv_ack_fall", 128'(cfg_ack_o), 128'(0));
        check("recv_ack_len", 128'(ackCnt), 128'(gapped ? 2 * TOTAL_TX - 1 : TOTAL_TX));
    endtask

    // expErr: 0 none, 1 timeout, 2 checksum
    task automatic collect(input logic [N_STAGE-1:0] mask, input logic [N_STAGE-1:0] doneVal, input int expErr);
        int loadCnt, vldCnt, doneCnt, wEntry, errCyc;
        logic [N_STAGE-1:0] loadVal;
        bit pushes;
        loadCnt = 0; vldCnt = 0; doneCnt = 0; wEntry = -1; errCyc = -1; loadVal = '0;
        stg_done_i = doneVal;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (stg_load_o != '0) begin
                loadCnt++;
                loadVal = stg_load_o;
            end
            if (stg_vld_o) begin
                if (vldCnt < BLK) begin
                    for (int k = 0; k < N_STAGE; k++) begin
                        check($sformatf("data_s%0d_w%0d", k, vldCnt),
                              128'(stg_data_o[k*COEF_W +: COEF_W]), 128'(frame[1 + BLK*k + vldCnt]));
                    end
                end
                vldCnt++;
            end else if (vldCnt > 0 && wEntry < 0) begin
                wEntry = c;
            end
            if (cfg_done_o) begin
                doneCnt++;
                tick();
                check("run_en", 128'(stg_en_o), 128'(mask));
                check("run_done_pulse", 128'(cfg_done_o), 128'(0));
                check("run_busy", 128'(busy_o), 128'(0));
                break;
            end
            if (cfg_err_o) begin
                errCyc = c;
                break;
            end
        end
        stg_done_i = '0;
        pushes = (mask != '0) && (expErr != 2);
        check("load_cnt", 128'(loadCnt), 128'(pushes ? 1 : 0));
        check("load_mask", 128'(loadVal), 128'(pushes ? mask : '0));
        check("vld_cnt", 128'(vldCnt), 128'(pushes ? BLK : 0));
        check("done_seen", 128'(doneCnt), 128'(expErr == 0 ? 1 : 0));
        check("err_seen", 128'(errCyc >= 0), 128'(expErr != 0));
        if (expErr == 1) check("tmo_cycles", 128'(errCyc - wEntry), 128'(TMO_CYC));
        if (expErr != 0) begin
            check("err_en", 128'(stg_en_o), 128'(0));
            check("err_busy", 128'(busy_o), 128'(0));
        end
        $display("frame mask=%02h done_in=%02h loads=%0d vld=%0d done=%0d err_cyc=%0d",
                 mask, doneVal, loadCnt, vldCnt, doneCnt, errCyc);
    endtask

    initial begin
        logic [N_STAGE-1:0] m;
        nRST = 1'b0;
        cfg_req_i = 1'b0;
        cfg_vld_i = 1'b0;
        cfg_data_i = '0;
        stg_done_i = '0;
        repeat (3) tick();
        checkAllZero("reset");
        nRST = 1'b1;
        tick();
        checkAllZero("post_reset");

        // full load, incrementing words, continuous valid
        buildFrame(5'h1F, 1'b1, 1'b0);
        sendFrame(1'b0);
        collect(5'h1F, 5'h1F, 0);

        // same frame, valid every other cycle
        sendFrame(1'b1);
        collect(5'h1F, 5'h1F, 0);

        // partial mask
        buildFrame(5'h05, 1'b0, 1'b0);
        sendFrame(1'b0);
        collect(5'h05, 5'h05, 0);

        // random masks, unmasked done bits set at random, random gapping
        for (int r = 0; r < 3; r++) begin
            m = N_STAGE'($urandom_range(1, 31));
            buildFrame(m, 1'b0, 1'b0);
            sendFrame(1'($urandom));
            collect(m, m | N_STAGE'($urandom), 0);
        end

        // empty mask: done without any push
        buildFrame(5'h00, 1'b0, 1'b0);
        sendFrame(1'b0);
        collect(5'h00, 5'h00, 0);

        // stage 3 never reports done
        buildFrame(5'h1F, 1'b0, 1'b0);
        sendFrame(1'b0);
        collect(5'h1F, 5'h17, 1);

        // new request clears the error and a normal frame follows
        buildFrame(5'h1A, 1'b0, 1'b0);
        sendFrame(1'b0);
        collect(5'h1A, 5'h1F, 0);

        // reset while pushing word 10
        buildFrame(5'h1F, 1'b0, 1'b0);
        sendFrame(1'b0);
        tick();
        check("push_start_vld", 128'(stg_vld_o), 128'(1));
        repeat (10) tick();
        check("push_w10", 128'(stg_data_o[0 +: COEF_W]), 128'(frame[1 + 10]));
        nRST = 1'b0;
        #1;
        checkAllZero("rst_push_async");
        tick();
        checkAllZero("rst_push");
        nRST = 1'b1;
        tick();
        checkAllZero("rst_push_rel");
        $display("frame aborted by reset at pcnt=10");

        buildFrame(5'h1F, 1'b0, 1'b0);
        sendFrame(1'b0);
        collect(5'h1F, 5'h1F, 0);

`ifdef CFG_CHECKSUM_EN
        buildFrame(5'h1F, 1'b0, 1'b1);
        sendFrame(1'b0);
        collect(5'h1F, 5'h1F, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
